icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, byte address width; ICACHE_NUM_SET, default 4, number of sets; ICACHE_NUM_WAYS, default 4, ways per set; LINE_BITS, default 128, line size in bits.
REQ-002 SHALL derive OFFSET_W=log2(LINE_BITS/8), SET_W=log2(ICACHE_NUM_SET), WAY_W=log2(ICACHE_NUM_WAYS), TAG_W=ADDR_WIDTH-SET_W-OFFSET_W.
REQ-003 SHALL have a single clock domain with asynchronous, active-low reset; ports as listed below.
REQ-004 Ports (name  direction  width  meaning):
 clock  in  1  system clock
 reset  in  1  asynchronous active-low reset
 miss_req  in  1  fetch reports a miss, sampled in IDLE only
 miss_addr  in  ADDR_WIDTH  missing fetch address
 hit_valid  in  1  fetch reports a hit, sampled in IDLE only
 hit_set  in  SET_W  set of hit
 hit_way  in  WAY_W  way of hit
 miss_busy  out  1  refill in progress
 miss_done  out  1  one-cycle pulse, line installed
 victim_req  out  1  victim lookup request to LRU
 victim_set  out  SET_W  set for victim lookup
 victim_way  in  WAY_W  LRU answer, same-cycle combinational
 update_req  out  1  LRU touch request
 update_set  out  SET_W  set to touch
 update_way  out  WAY_W  way to touch
 mem_req  out  1  line read request
 mem_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero)
 mem_req_ready  in  1  memory accepts request
 mem_rsp_valid  in  1  line data valid
 mem_rsp_data  in  LINE_BITS  returned line
 fill_valid  out  1  write tag/data/valid into arrays
 fill_set  out  SET_W  fill set
 fill_way  out  WAY_W  fill way
 fill_tag  out  TAG_W  fill tag
 fill_data  out  LINE_BITS  fill line

Function
REQ-005 SHALL implement FSM IDLE, VICTIM, MEM_REQ, MEM_WAIT, FILL; all outputs registered or decoded from state/captured registers only.
REQ-006 IDLE: miss_req=1 -> capture miss_addr, go VICTIM; otherwise stay.
REQ-007 VICTIM: victim_req=1, victim_set=captured set for exactly one cycle; capture victim_way at end of cycle; go MEM_REQ.
REQ-008 MEM_REQ: mem_req=1, mem_addr={tag,set,OFFSET_W'b0} held stable until mem_req_ready=1; go MEM_WAIT on that cycle.
REQ-009 MEM_WAIT: on mem_rsp_valid=1 capture mem_rsp_data, go FILL; wait indefinitely otherwise.
REQ-010 FILL: for exactly one cycle fill_valid=1, update_req=1 (set/way = captured set/victim), miss_done=1; go IDLE.
REQ-011 Latency: miss_req cycle N -> victim_req N+1, mem_req N+2 earliest; mem_rsp_valid cycle M -> fill_valid/miss_done M+1; min miss-to-done 4 cycles with zero-wait memory.
REQ-012 miss_busy SHALL be 1 in every state except IDLE.
REQ-013 hit_valid in IDLE SHALL produce update_req with registered hit_set/hit_way the next cycle, one cycle wide.
REQ-014 miss_req and hit_valid in the same IDLE cycle SHALL both be accepted; hit update issues in the VICTIM cycle.
REQ-015 miss_req, hit_valid outside IDLE SHALL be ignored; mem_rsp_valid outside MEM_WAIT SHALL be ignored.
REQ-016 update_req SHALL never be asserted by both sources in one cycle (guaranteed by REQ-013/015).
REQ-017 Back-to-back: miss_req in the IDLE cycle after FILL SHALL start a new refill normally.

Reset
REQ-018 reset=0 SHALL asynchronously force IDLE and all outputs to 0, including captured address, victim, data and pending hit.
REQ-019 Reset mid-refill SHALL abandon the transaction; a later mem_rsp_valid SHALL be ignored; no fill or miss_done emitted.

Verification
REQ-020 Miss 0x0000_1234, victim_way=2, ready and rsp immediate -> mem_addr 0x0000_1230, fill_set=3, fill_way=2, fill_tag=0x000_0048, miss_done 4 cycles after miss_req.
REQ-021 mem_req_ready held low 5 cycles -> mem_req and mem_addr stable all 5 cycles; single request accepted.
REQ-022 hit_valid set=1 way=3 in IDLE -> update_req=1, update_set=1, update_way=3 next cycle only.
REQ-023 Miss and hit same cycle -> hit update in VICTIM cycle, fill update in FILL cycle, never overlapping.
REQ-024 Spurious mem_rsp_valid in IDLE and miss_req during MEM_WAIT -> no state change, no extra mem_req.
REQ-025 reset asserted in MEM_WAIT, rsp arrives after release -> all outputs 0, no fill_valid, miss_busy=0.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill sequencer: victim lookup, line fetch, array fill,
// and LRU touch arbitration between hits and completed refills.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ICACHE_NUM_SET  = 4,
  parameter int unsigned ICACHE_NUM_WAYS = 4,
  parameter int unsigned LINE_BITS       = 128,
  localparam int unsigned OFFSET_W = $clog2(LINE_BITS / 8),
  localparam int unsigned SET_W    = $clog2(ICACHE_NUM_SET),
  localparam int unsigned WAY_W    = $clog2(ICACHE_NUM_WAYS),
  localparam int unsigned TAG_W    = ADDR_WIDTH - SET_W - OFFSET_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  hit_valid,
  input  logic [SET_W-1:0]      hit_set,
  input  logic [WAY_W-1:0]      hit_way,
  output logic                  miss_busy,
  output logic                  miss_done,
  output logic                  victim_req,
  output logic [SET_W-1:0]      victim_set,
  input  logic [WAY_W-1:0]      victim_way,
  output logic                  update_req,
  output logic [SET_W-1:0]      update_set,
  output logic [WAY_W-1:0]      update_way,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_BITS-1:0]  mem_rsp_data,
  output logic                  fill_valid,
  output logic [SET_W-1:0]      fill_set,
  output logic [WAY_W-1:0]      fill_way,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [LINE_BITS-1:0]  fill_data
);

  localparam int unsigned LINE_W = ADDR_WIDTH - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    VICTIM,
    MEM_REQ,
    MEM_WAIT,
    FILL
  } state_e;

  state_e               state_q, state_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic [LINE_BITS-1:0] data_q, data_d;
  logic                 hit_pend_q, hit_pend_d;
  logic [SET_W-1:0]     hit_set_q, hit_set_d;
  logic [WAY_W-1:0]     hit_way_q, hit_way_d;

  logic [SET_W-1:0]     set_w;
  logic [TAG_W-1:0]     tag_w;
  logic                 in_fill;
  logic                 unused_offset;

  // Byte-offset bits of the miss address never matter: refills are whole lines.
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  assign set_w = line_q[SET_W-1:0];
  assign tag_w = line_q[LINE_W-1:SET_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      victim_q   <= '0;
      data_q     <= '0;
      hit_pend_q <= 1'b0;
      hit_set_q  <= '0;
      hit_way_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      victim_q   <= victim_d;
      data_q     <= data_d;
      hit_pend_q <= hit_pend_d;
      hit_set_q  <= hit_set_d;
      hit_way_q  <= hit_way_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    victim_d   = victim_q;
    data_d     = data_q;
    hit_pend_d = 1'b0;
    hit_set_d  = hit_set_q;
    hit_way_d  = hit_way_q;

    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          line_d  = miss_addr[ADDR_WIDTH-1:OFFSET_W];
          state_d = VICTIM;
        end
        // A hit is only ever latched here, so its touch lands in IDLE or VICTIM,
        // never in FILL where the refill owns the LRU update port.
        if (hit_valid) begin
          hit_pend_d = 1'b1;
          hit_set_d  = hit_set;
          hit_way_d  = hit_way;
        end
      end
      VICTIM: begin
        victim_d = victim_way;
        state_d  = MEM_REQ;
      end
      MEM_REQ: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_fill    = (state_q == FILL);
  assign miss_busy  = (state_q != IDLE);
  assign miss_done  = in_fill;
  assign victim_req = (state_q == VICTIM);
  assign victim_set = set_w;
  assign mem_req    = (state_q == MEM_REQ);
  assign mem_addr   = {tag_w, set_w, {OFFSET_W{1'b0}}};
  assign fill_valid = in_fill;
  assign fill_set   = set_w;
  assign fill_way   = victim_q;
  assign fill_tag   = tag_w;
  assign fill_data  = data_q;
  assign update_req = hit_pend_q | in_fill;
  assign update_set = in_fill ? set_w : hit_set_q;
  assign update_way = in_fill ? victim_q : hit_way_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl against a transaction-level model.
module tb_icache_refill_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         hit_valid;
  logic [1:0]   hit_set;
  logic [1:0]   hit_way;
  logic         miss_busy;
  logic         miss_done;
  logic         victim_req;
  logic [1:0]   victim_set;
  logic [1:0]   victim_way;
  logic         update_req;
  logic [1:0]   update_set;
  logic [1:0]   update_way;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         fill_valid;
  logic [1:0]   fill_set;
  logic [1:0]   fill_way;
  logic [25:0]  fill_tag;
  logic [127:0] fill_data;

  int tests = 0;
  int fails = 0;

  icache_refill_ctrl #(
    .ADDR_WIDTH     (32),
    .ICACHE_NUM_SET (4),
    .ICACHE_NUM_WAYS(4),
    .LINE_BITS      (128)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .hit_valid    (hit_valid),
    .hit_set      (hit_set),
    .hit_way      (hit_way),
    .miss_busy    (miss_busy),
    .miss_done    (miss_done),
    .victim_req   (victim_req),
    .victim_set   (victim_set),
    .victim_way   (victim_way),
    .update_req   (update_req),
    .update_set   (update_set),
    .update_way   (update_way),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .fill_valid   (fill_valid),
    .fill_set     (fill_set),
    .fill_way     (fill_way),
    .fill_tag     (fill_tag),
    .fill_data    (fill_data)
  );

  always #5 clock = ~clock;

  logic any_out;
  assign any_out = |{miss_busy, miss_done, victim_req, victim_set, update_req, update_set,
                     update_way, mem_req, mem_addr, fill_valid, fill_set, fill_way,
                     fill_tag, fill_data};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    miss_req      = 1'b0;
    hit_valid     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  // One complete miss, starting from an IDLE cycle (just after an edge).
  // Expected values come from plain address arithmetic: 16-byte lines, 4 sets.
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] vway,
                          input int rdly, input int wdly, input logic [127:0] data,
                          input bit hit, input logic [1:0] hset, input logic [1:0] hway,
                          input bit noise);
    logic [31:0] e_addr;
    logic [1:0]  e_set;
    logic [25:0] e_tag;
    e_addr = addr & 32'hFFFF_FFF0;
    e_set  = 2'((addr >> 4) % 4);
    e_tag  = 26'(addr >> 6);

    chk("idle_busy", miss_busy, 1'b0);
    miss_req  = 1'b1;
    miss_addr = addr;
    hit_valid = hit;
    hit_set   = hset;
    hit_way   = hway;
    cyc();
    // VICTIM cycle
    chk("victim_req", victim_req, 1'b1);
    chk("victim_set", victim_set, e_set);
    chk("victim_busy", miss_busy, 1'b1);
    chk("victim_memreq", mem_req, 1'b0);
    chk("victim_upd", update_req, hit);
    if (hit) begin
      chk("hit_upd_set", update_set, hset);
      chk("hit_upd_way", update_way, hway);
    end
    victim_way    = vway;
    miss_req      = noise;
    miss_addr     = $urandom;
    hit_valid     = noise;
    hit_set       = 2'($urandom);
    hit_way       = 2'($urandom);
    mem_rsp_valid = noise;
    cyc();
    hit_valid     = 1'b0;
    victim_way    = 2'($urandom);
    // MEM_REQ held until accepted
    for (int i = 0; i <= rdly; i++) begin
      chk("memreq", mem_req, 1'b1);
      chk("memaddr", mem_addr, e_addr);
      chk("memreq_victim", victim_req, 1'b0);
      chk("memreq_upd", update_req, 1'b0);
      mem_req_ready = (i == rdly);
      cyc();
    end
    mem_req_ready = 1'b0;
    // MEM_WAIT
    for (int j = 0; j <= wdly; j++) begin
      chk("wait_memreq", mem_req, 1'b0);
      chk("wait_fill", fill_valid, 1'b0);
      chk("wait_busy", miss_busy, 1'b1);
      miss_req      = noise;
      mem_rsp_valid = (j == wdly);
      mem_rsp_data  = (j == wdly) ? data : ~data;
      cyc();
    end
    idle_inputs();
    mem_rsp_data = {4{$urandom}};
    // FILL
    chk("fill_valid", fill_valid, 1'b1);
    chk("fill_set", fill_set, e_set);
    chk("fill_way", fill_way, vway);
    chk("fill_tag", fill_tag, e_tag);
    chk("fill_data", fill_data, data);
    chk("miss_done", miss_done, 1'b1);
    chk("fill_upd", update_req, 1'b1);
    chk("fill_upd_set", update_set, e_set);
    chk("fill_upd_way", update_way, vway);
    chk("fill_memreq", mem_req, 1'b0);
    cyc();
    chk("post_done", miss_done, 1'b0);
    chk("post_fill", fill_valid, 1'b0);
    chk("post_busy", miss_busy, 1'b0);
    chk("post_upd", update_req, 1'b0);
  endtask

  initial begin
    idle_inputs();
    miss_addr    = '0;
    hit_set      = '0;
    hit_way      = '0;
    victim_way   = '0;
    mem_rsp_data = '0;
    reset        = 1'b0;
    #2;
    chk("reset_outputs", any_out, 1'b0);
    cyc();
    cyc();
    chk("reset_outputs_held", any_out, 1'b0);
    reset = 1'b1;
    cyc();

    // Reference miss with zero-wait memory: done exactly 4 cycles after miss_req.
    run_miss(32'h0000_1234, 2'd2, 0, 0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA,
             1'b0, 2'd0, 2'd0, 1'b0);

    // Slow memory acceptance: request held for several cycles, accepted once.
    run_miss(32'h8765_43FC, 2'd1, 4, 2, {4{32'hC0FF_EE00}}, 1'b0, 2'd0, 2'd0, 1'b0);

    // Standalone hit touch: one cycle wide, next cycle only.
    hit_valid = 1'b1;
    hit_set   = 2'd1;
    hit_way   = 2'd3;
    cyc();
    hit_valid = 1'b0;
    chk("hit_upd", update_req, 1'b1);
    chk("hit_set", update_set, 2'd1);
    chk("hit_way", update_way, 2'd3);
    chk("hit_busy", miss_busy, 1'b0);
    cyc();
    chk("hit_upd_once", update_req, 1'b0);

    // Miss and hit together, with ignored traffic during the refill.
    run_miss(32'h0000_0010, 2'd0, 1, 3, {4{32'h1357_9BDF}}, 1'b1, 2'd2, 2'd1, 1'b1);

    // Spurious response while idle.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '1;
    cyc();
    cyc();
    chk("spur_busy", miss_busy, 1'b0);
    chk("spur_memreq", mem_req, 1'b0);
    chk("spur_fill", fill_valid, 1'b0);
    chk("spur_done", miss_done, 1'b0);
    mem_rsp_valid = 1'b0;

    // Back-to-back refills beginning right after each FILL.
    for (int k = 0; k < 24; k++) begin
      run_miss($urandom, 2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
               2'($urandom), 2'($urandom), 1'($urandom));
    end

    // Reset in MEM_WAIT abandons the refill; a later response must not fill.
    miss_req  = 1'b1;
    miss_addr = 32'hABCD_EF78;
    hit_valid = 1'b1;
    hit_set   = 2'd3;
    hit_way   = 2'd2;
    cyc();
    idle_inputs();
    victim_way = 2'd3;
    cyc();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    chk("rst_wait_busy", miss_busy, 1'b1);
    chk("rst_wait_memreq", mem_req, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_outputs", any_out, 1'b0);
    cyc();
    reset      = 1'b1;
    victim_way = '0;
    for (int r = 0; r < 3; r++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {4{32'hFACE_B00C}};
      cyc();
      chk("rst_after_fill", fill_valid, 1'b0);
      chk("rst_after_done", miss_done, 1'b0);
      chk("rst_after_busy", miss_busy, 1'b0);
      chk("rst_after_all", any_out, 1'b0);
    end
    mem_rsp_valid = 1'b0;

    // Normal operation resumes after the abandoned refill.
    run_miss(32'h0000_0FF0, 2'd3, 0, 1, {4{32'h0F0F_0F0F}}, 1'b0, 2'd0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
